cache_traffic_gen: RTL and testbench

//  Synthesizable, parametrised CPU-side traffic generator for the L1/L2/memory hierarchy.

---
 rtl/cache_traffic_gen_if.sv | 23 ++
 rtl/cache_traffic_gen.sv | 214 +++++++++++++++++++++
 tb/tb_cache_traffic_gen.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_traffic_gen_if.sv
// CPU-side request/response bus between the traffic generator and the L1 cache.
interface cache_traffic_gen_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [DATA_WIDTH-1:0] cpu_data_out;
    logic                  cpu_ready;

    // Generator side drives requests, cache side answers.
    modport master (
        output cpu_addr, cpu_data_in, cpu_read, cpu_write,
        input  cpu_data_out, cpu_ready
    );

    modport slave (
        input  cpu_addr, cpu_data_in, cpu_read, cpu_write,
        output cpu_data_out, cpu_ready
    );
endinterface

// File: rtl/cache_traffic_gen.sv
// CPU-side traffic generator: LFSR-addressed read/write requests, completion
// counting and timeout detection. Define TG_SCOREBOARD_EN to add a shadow
// memory that checks read data against previously written values.
module cache_traffic_gen #(
    parameter int unsigned          ADDR_WIDTH   = 11,
    parameter int unsigned          DATA_WIDTH   = 8,
    parameter logic [15:0]          SEED         = 16'hACE1,
    parameter int unsigned          WRITE_RATIO  = 64,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_MASK   = '1,
    parameter int unsigned          ISSUE_CYCLES = 2,
    parameter int unsigned          TIMEOUT      = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [31:0]            num_txn,
    cache_traffic_gen_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            txn_count,
    output logic [15:0]            err_count,
    output logic [ADDR_WIDTH-1:0]  err_addr
);
    localparam logic [15:0] LFSR_SEED = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int unsigned ISS_W     = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam int unsigned TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_GEN, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [31:0]            num_txn_q, num_txn_d;
    logic [ISS_W-1:0]       iss_cnt_q, iss_cnt_d;
    logic [TMR_W-1:0]       tmr_cnt_q, tmr_cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic                   is_write_q, is_write_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [31:0]            txn_cnt_q, txn_cnt_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
    logic                   err_inc_c;
    logic                   mismatch_c;

`ifdef TG_SCOREBOARD_EN
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  shadow_mem_q [DEPTH];
    logic [DEPTH-1:0]       shadow_vld_q, shadow_vld_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    // Capture read data on completion and mark written shadow entries valid.
    always_comb begin
        rdata_d      = rdata_q;
        shadow_vld_d = shadow_vld_q;
        if (state_q == S_WAIT && bus.cpu_ready)
            rdata_d = bus.cpu_data_out;
        if (state_q == S_CHECK && is_write_q)
            shadow_vld_d[addr_q] = 1'b1;
    end

    // Shadow valid bits and captured read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q      <= '0;
            shadow_vld_q <= '0;
        end else begin
            rdata_q      <= rdata_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    // Shadow data storage, written when a write completes.
    always_ff @(posedge clk) begin
        if (state_q == S_CHECK && is_write_q)
            shadow_mem_q[addr_q] <= wdata_q;
    end

    assign mismatch_c = (state_q == S_CHECK) && !is_write_q && shadow_vld_q[addr_q]
                        && (rdata_q != shadow_mem_q[addr_q]);
`else
    logic unused_rdata_c;
    assign unused_rdata_c = ^bus.cpu_data_out;
    assign mismatch_c     = 1'b0;
`endif

    // Next-state and output computation for the request sequencer.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        num_txn_d  = num_txn_q;
        iss_cnt_d  = iss_cnt_q;
        tmr_cnt_d  = tmr_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        is_write_d = is_write_q;
        txn_cnt_d  = txn_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        err_inc_c  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_txn_d  = num_txn;
                    txn_cnt_d  = '0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    state_d    = (num_txn == 32'd0) ? S_DONE : S_GEN;
                end
            end
            S_GEN: begin
                addr_d     = (lfsr_q[ADDR_WIDTH-1:0] & ADDR_MASK) | ADDR_BASE;
                is_write_d = 32'(lfsr_q[15:8]) < WRITE_RATIO;
                wdata_d    = lfsr_q[DATA_WIDTH-1:0] ^ txn_cnt_q[DATA_WIDTH-1:0];
                rd_d       = !is_write_d;
                wr_d       = is_write_d;
                lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
                iss_cnt_d  = '0;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                if (iss_cnt_q == ISS_W'(ISSUE_CYCLES - 1)) begin
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    tmr_cnt_d = '0;
                    state_d   = S_WAIT;
                end else begin
                    iss_cnt_d = iss_cnt_q + ISS_W'(1);
                end
            end
            S_WAIT: begin
                if (bus.cpu_ready) begin
                    state_d = S_CHECK;
                end else if (tmr_cnt_q == TMR_W'(TIMEOUT - 1)) begin
                    err_inc_c = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmr_cnt_d = tmr_cnt_q + TMR_W'(1);
                end
            end
            S_CHECK: begin
                txn_cnt_d = txn_cnt_q + 32'd1;
                err_inc_c = mismatch_c;
                state_d   = (txn_cnt_d == num_txn_q) ? S_DONE : S_GEN;
            end
            default: state_d = S_IDLE;
        endcase

        // Saturating error count; first error address is kept.
        if (err_inc_c) begin
            if (err_cnt_q != 16'hFFFF)
                err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0)
                err_addr_d = addr_q;
        end

        busy_d = (state_d == S_GEN) || (state_d == S_ISSUE) ||
                 (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            num_txn_q  <= '0;
            iss_cnt_q  <= '0;
            tmr_cnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            is_write_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            txn_cnt_q  <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            num_txn_q  <= num_txn_d;
            iss_cnt_q  <= iss_cnt_d;
            tmr_cnt_q  <= tmr_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            is_write_q <= is_write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            txn_cnt_q  <= txn_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.cpu_addr    = addr_q;
    assign bus.cpu_data_in = wdata_q;
    assign bus.cpu_read    = rd_q;
    assign bus.cpu_write   = wr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign txn_count       = txn_cnt_q;
    assign err_count       = err_cnt_q;
    assign err_addr        = err_addr_q;
endmodule

// File: tb/tb_cache_traffic_gen.sv
// Bench for cache_traffic_gen: reference LFSR request model, responding
// memory with optional read corruption, table of runs plus corner sequences.
module tb_cache_traffic_gen;
    localparam int unsigned AW   = 11;
    localparam int unsigned DW   = 8;
    localparam int unsigned TMO  = 16;
    localparam int unsigned WR   = 128;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [10:0] MASK = 11'h00F;
    localparam logic [10:0] BASE = 11'h000;
`ifdef TG_SCOREBOARD_EN
    localparam bit SB_ON = 1'b1;
`else
    localparam bit SB_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   num_txn = '0;
    logic          busy, done;
    logic [31:0]   txn_count;
    logic [15:0]   err_count;
    logic [AW-1:0] err_addr;

    always #5 clk = ~clk;

    cache_traffic_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cache_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEED(SEED), .WRITE_RATIO(WR),
        .ADDR_BASE(BASE), .ADDR_MASK(MASK), .ISSUE_CYCLES(2), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_txn(num_txn), .bus(bus),
        .busy(busy), .done(done), .txn_count(txn_count), .err_count(err_count),
        .err_addr(err_addr)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    typedef struct packed {
        logic [10:0] addr;
        logic        wr;
        logic [7:0]  data;
    } req_t;

    typedef struct {
        int n;
        int lat;
        bit corrupt;
        bit tmo;
        int exp_txn;
    } vec_t;

    req_t        exp_q[$];
    logic [15:0] ref_lfsr;
    int          pop_cnt;
    int          lat = 1;
    bit          corrupt = 1'b0;
    int          exp_err;
    logic [10:0] exp_err_addr;
    logic [10:0] last_addr;
    time         req_time, done_time;
    int          req_total = 0;
    bit [7:0]    mem [2048];
    bit          vld [2048];

    // Monitor/responder state
    bit          in_req, waiting, cur_wr;
    logic [10:0] cur_addr;
    logic [7:0]  cur_data;
    int          plen, wcnt;

    // Request monitor and memory responder, evaluated away from the active edge.
    always @(negedge clk) begin
        req_t       e;
        logic [7:0] rdata;
        if (!rst_n) begin
            in_req = 1'b0;
            waiting = 1'b0;
            bus.cpu_ready = 1'b0;
            bus.cpu_data_out = '0;
        end else begin
            bus.cpu_ready = 1'b0;
            if (!busy) waiting = 1'b0;
            if (bus.cpu_read || bus.cpu_write) begin
                check("req_onehot", 32'(bus.cpu_read & bus.cpu_write), 32'd0);
                if (!in_req) begin
                    in_req = 1'b1;
                    waiting = 1'b0;
                    plen = 1;
                    cur_addr = bus.cpu_addr;
                    cur_wr = bus.cpu_write;
                    cur_data = bus.cpu_data_in;
                    last_addr = cur_addr;
                    req_time = $time;
                    req_total++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        pop_cnt++;
                        check("req_addr", 32'(cur_addr), 32'(e.addr));
                        check("req_write", 32'(cur_wr), 32'(e.wr));
                        check("req_data", 32'(cur_data), 32'(e.data));
                    end
                end else begin
                    plen++;
                    check("addr_stable", 32'(bus.cpu_addr), 32'(cur_addr));
                end
            end else if (in_req) begin
                in_req = 1'b0;
                check("pulse_len", 32'(plen), 32'd2);
                waiting = 1'b1;
                wcnt = 0;
            end
            if (waiting && lat > 0) begin
                wcnt++;
                if (wcnt >= lat) begin
                    waiting = 1'b0;
                    rdata = mem[cur_addr];
                    if (cur_wr) begin
                        mem[cur_addr] = cur_data;
                        vld[cur_addr] = 1'b1;
                    end else if (corrupt && cur_addr == 11'h005) begin
                        rdata[0] = ~rdata[0];
                        if (SB_ON && vld[cur_addr]) begin
                            if (exp_err == 0) exp_err_addr = cur_addr;
                            exp_err++;
                        end
                    end
                    bus.cpu_ready = 1'b1;
                    bus.cpu_data_out = rdata;
                end
            end
        end
    end

    // Push the expected request stream for a run, then pulse start.
    task automatic do_start(input int n);
        logic [15:0] l;
        req_t        e;
        l = ref_lfsr;
        exp_q.delete();
        pop_cnt = 0;
        exp_err = 0;
        exp_err_addr = '0;
        for (int k = 0; k < n; k++) begin
            e.addr = (l[10:0] & MASK) | BASE;
            e.wr   = 32'(l[15:8]) < WR;
            e.data = l[7:0] ^ 8'(k);
            exp_q.push_back(e);
            l = lfsr_next(l);
        end
        start = 1'b1;
        num_txn = 32'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; commits the reference LFSR by the requests seen.
    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        done_time = $time;
        if (!seen) check("done_wait_expired", 32'd0, 32'd1);
        for (int i = 0; i < pop_cnt; i++) ref_lfsr = lfsr_next(ref_lfsr);
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{n: 100, lat: 3, corrupt: 1'b0, tmo: 1'b0, exp_txn: 100};
        vecs[1] = '{n: 500, lat: 1, corrupt: 1'b0, tmo: 1'b0, exp_txn: 500};
        vecs[2] = '{n: 7,   lat: 5, corrupt: 1'b0, tmo: 1'b0, exp_txn: 7};
        vecs[3] = '{n: 200, lat: 2, corrupt: 1'b1, tmo: 1'b0, exp_txn: 200};
        vecs[4] = '{n: 3,   lat: 0, corrupt: 1'b0, tmo: 1'b1, exp_txn: 0};
        vecs[5] = '{n: 1,   lat: 4, corrupt: 1'b0, tmo: 1'b0, exp_txn: 1};
        ref_lfsr = SEED;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(bus.cpu_addr), 32'd0);
        check("rst_read", 32'(bus.cpu_read), 32'd0);
        check("rst_write", 32'(bus.cpu_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_txn", txn_count, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-length run: done one cycle after start, no request issued
        do_start(0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("zero_no_req", 32'(req_total), 32'd0);
        check("zero_txn", txn_count, 32'd0);

        // Table of runs
        for (int i = 0; i < 6; i++) begin
            lat = vecs[i].lat;
            corrupt = vecs[i].corrupt;
            do_start(vecs[i].n);
            wait_done(vecs[i].n * 20 + 100);
            if (vecs[i].tmo) begin
                if (exp_err == 0) exp_err_addr = last_addr;
                exp_err++;
                check("tmo_latency", 32'((done_time - req_time) / 10), 32'd18);
            end
            check("vec_txn", txn_count, 32'(vecs[i].exp_txn));
            check("vec_err", 32'(err_count), 32'(exp_err));
            check("vec_err_addr", 32'(err_addr), 32'(exp_err_addr));
            check("vec_done", 32'(done), 32'd1);
            check("vec_busy", 32'(busy), 32'd0);
        end
        corrupt = 1'b0;

        // Start while busy is ignored
        lat = 2;
        do_start(5);
        repeat (3) @(negedge clk);
        start = 1'b1;
        num_txn = 32'd999;
        @(negedge clk);
        start = 1'b0;
        wait_done(300);
        check("busy_start_txn", txn_count, 32'd5);
        check("busy_start_err", 32'(err_count), 32'd0);

        // Reset asserted during WAIT
        lat = 8;
        do_start(50);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (waiting) break;
        end
        check("abort_in_run", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_read", 32'(bus.cpu_read), 32'd0);
        check("abort_write", 32'(bus.cpu_write), 32'd0);
        check("abort_addr", 32'(bus.cpu_addr), 32'd0);
        check("abort_wdata", 32'(bus.cpu_data_in), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_txn", txn_count, 32'd0);
        repeat (2) @(negedge clk);
        ref_lfsr = SEED;
        exp_q.delete();
        for (int a = 0; a < 2048; a++) vld[a] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Restart reproduces the sequence from the seed
        lat = 2;
        do_start(10);
        wait_done(400);
        check("restart_txn", txn_count, 32'd10);
        check("restart_err", 32'(err_count), 32'd0);
        check("restart_done", 32'(done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
